imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_pkg.sv | 19 +
 rtl/imem_if.sv | 24 ++
 rtl/imem_ram.sv | 32 +++
 rtl/imem_responder.sv | 138 +++++++++++++
 tb/tb_imem_responder.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and default parameters for the instruction-memory responder.
// Holds the FSM state enum and a range-check helper.
package imem_pkg;

    localparam int unsigned DEF_DEPTH_WORDS = 1024;
    localparam int unsigned DEF_LATENCY     = 2;
    localparam logic [31:0] DEF_BASE_ADDR   = 32'h0000_0000;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    // off is already rebased to word 0; addresses below the base wrap huge and fail here
    function automatic logic in_range(input logic [31:0] off, input int unsigned depth);
        return (64'(off) < (64'(depth) * 64'd8));
    endfunction

endpackage

// File: rtl/imem_if.sv
// Fetch/response and boot-load bus between the fetcher and the responder.
interface imem_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_valid;
    logic [63:0] imem_data;
    logic        imem_err;
    logic        load_en;
    logic [31:0] load_addr;
    logic [63:0] load_data;

    modport master (
        output imem_req, imem_addr, load_en, load_addr, load_data,
        input  imem_ready, imem_valid, imem_data, imem_err
    );

    modport slave (
        input  imem_req, imem_addr, load_en, load_addr, load_data,
        output imem_ready, imem_valid, imem_data, imem_err
    );

endinterface

// File: rtl/imem_ram.sv
// Single-port 64-bit synchronous RAM, one-cycle registered read.
// A write cycle does not update the read register.
module imem_ram
    import imem_pkg::*;
#(
    parameter  int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    localparam int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          i_en,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [63:0]   i_wdata,
    output logic [63:0]   o_rdata
);

    logic [63:0] r_mem [DEPTH_WORDS];
    logic [63:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_addr] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_addr];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: zero-fills the RAM after reset, then serves
// pipelined fetches with fixed latency and accepts boot-loader writes.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int unsigned LATENCY     = DEF_LATENCY,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic  clk,
    input  logic  resetn,
    imem_if.slave bus
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_t        r_state;
    logic [AW-1:0] r_cnt;

    logic [31:0]   w_fetch_off;
    logic [31:0]   w_load_off;
    logic          w_fetch_fault;
    logic          w_load_ok;
    logic          w_acc;

    logic          w_ram_en;
    logic          w_ram_we;
    logic [AW-1:0] w_ram_addr;
    logic [63:0]   w_ram_wdata;
    logic [63:0]   w_ram_rdata;

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_err;
    logic [63:0]        w_s0_data;

    assign w_fetch_off   = bus.imem_addr - BASE_ADDR;
    assign w_load_off    = bus.load_addr - BASE_ADDR;
    assign w_fetch_fault = (bus.imem_addr[1:0] != 2'b00) || !in_range(w_fetch_off, DEPTH_WORDS);
    assign w_load_ok     = in_range(w_load_off, DEPTH_WORDS);

    // resetn gating keeps ready low during the reset cycle itself
    assign bus.imem_ready = resetn && (r_state == RUN) && !bus.load_en;
    assign w_acc          = bus.imem_req && bus.imem_ready;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                INIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == AW'(DEPTH_WORDS - 1)) begin
                        r_state <= RUN;
                    end
                end
                RUN:     r_state <= RUN;
                default: r_state <= INIT;
            endcase
        end
    end

    // One RAM port: zero-fill beats loads, loads beat fetches; faults never read
    always_comb begin
        w_ram_en    = 1'b0;
        w_ram_we    = 1'b0;
        w_ram_addr  = '0;
        w_ram_wdata = '0;
        if (r_state == INIT) begin
            w_ram_en   = 1'b1;
            w_ram_we   = 1'b1;
            w_ram_addr = r_cnt;
        end else if (bus.load_en) begin
            if (resetn && w_load_ok) begin
                w_ram_en    = 1'b1;
                w_ram_we    = 1'b1;
                w_ram_addr  = w_load_off[AW+2:3];
                w_ram_wdata = bus.load_data;
            end
        end else if (w_acc && !w_fetch_fault) begin
            w_ram_en   = 1'b1;
            w_ram_addr = w_fetch_off[AW+2:3];
        end
    end

    imem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_ram_en),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_rdata)
    );

    // Stage 0 lines up with the RAM read register; later stages are pure delay
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_vld <= '0;
            r_err <= '0;
        end else begin
            r_vld[0] <= w_acc;
            r_err[0] <= w_acc && w_fetch_fault;
            for (int k = 1; k < int'(LATENCY); k++) begin
                r_vld[k] <= r_vld[k-1];
                r_err[k] <= r_err[k-1];
            end
        end
    end

    assign w_s0_data = (r_vld[0] && !r_err[0]) ? w_ram_rdata : 64'h0;

    generate
        if (LATENCY == 1) begin : g_direct
            assign bus.imem_data = w_s0_data;
        end else begin : g_dpipe
            logic [63:0] r_dat [LATENCY-1:1];
            always_ff @(posedge clk) begin
                if (!resetn) begin
                    for (int k = 1; k < int'(LATENCY); k++) begin
                        r_dat[k] <= 64'h0;
                    end
                end else begin
                    r_dat[1] <= w_s0_data;
                    for (int k = 2; k < int'(LATENCY); k++) begin
                        r_dat[k] <= r_dat[k-1];
                    end
                end
            end
            assign bus.imem_data = r_dat[LATENCY-1];
        end
    endgenerate

    assign bus.imem_valid = r_vld[LATENCY-1];
    assign bus.imem_err   = r_vld[LATENCY-1] && r_err[LATENCY-1];

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder (DEPTH 1024, LATENCY 2, base 0).
module tb_imem_responder;
    import imem_pkg::*;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    int   total  = 0;
    int   bad    = 0;
    int   n;
    int   vseen;

    localparam logic [63:0] D_A  = 64'h1111_2222_3333_4444;
    localparam logic [63:0] D_B  = 64'h5555_6666_7777_8888;
    localparam logic [63:0] D_C  = 64'hDEAD_BEEF_0000_0013;
    localparam logic [63:0] D_C2 = 64'h0123_4567_89AB_CDEF;

    always #5 clk = ~clk;

    imem_if bus ();

    imem_responder dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the response slot
    task automatic fetch(input string tag, input logic [31:0] a, input logic [63:0] d, input logic e);
        bus.imem_req  = 1'b1;
        bus.imem_addr = a;
        #1 chk({tag, ".ready"}, 64'(bus.imem_ready), 64'd1);
        @(negedge clk);
        bus.imem_req = 1'b0;
        chk({tag, ".early"}, 64'(bus.imem_valid), 64'd0);
        @(negedge clk);
        chk({tag, ".valid"}, 64'(bus.imem_valid), 64'd1);
        chk({tag, ".data"}, bus.imem_data, d);
        chk({tag, ".err"}, 64'(bus.imem_err), 64'(e));
        @(negedge clk);
        chk({tag, ".late"}, 64'(bus.imem_valid), 64'd0);
        chk({tag, ".idle_data"}, bus.imem_data, 64'd0);
    endtask

    task automatic load(input logic [31:0] a, input logic [63:0] d);
        bus.load_en   = 1'b1;
        bus.load_addr = a;
        bus.load_data = d;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    task automatic wait_run(output int cycles, output int vcount);
        cycles = 0;
        vcount = 0;
        #1;
        while (!bus.imem_ready && cycles < 3000) begin
            cycles++;
            if (bus.imem_valid) vcount++;
            @(negedge clk);
            #1;
        end
        @(negedge clk);
    endtask

    initial begin
        bus.imem_req  = 1'b0;
        bus.imem_addr = 32'h0;
        bus.load_en   = 1'b0;
        bus.load_addr = 32'h0;
        bus.load_data = 64'h0;

        // reset state
        @(negedge clk);
        @(negedge clk);
        chk("rst.valid", 64'(bus.imem_valid), 64'd0);
        chk("rst.err", 64'(bus.imem_err), 64'd0);
        chk("rst.data", bus.imem_data, 64'd0);
        chk("rst.ready", 64'(bus.imem_ready), 64'd0);

        // INIT length
        resetn = 1'b1;
        wait_run(n, vseen);
        chk("init.cycles", 64'(n), 64'd1024);
        chk("init.novalid", 64'(vseen), 64'd0);
        chk("run.ready", 64'(bus.imem_ready), 64'd1);
        fetch("f0", 32'h0, 64'h0, 1'b0);

        // load then fetch the other half of the same doubleword
        load(32'h10, D_C);
        fetch("f14", 32'h14, D_C, 1'b0);

        // back-to-back fetches
        load(32'h0, D_A);
        load(32'h8, D_B);
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h0;
        #1 chk("b2b.ready", 64'(bus.imem_ready), 64'd1);
        @(negedge clk);
        bus.imem_addr = 32'h8;
        chk("b2b.early", 64'(bus.imem_valid), 64'd0);
        @(negedge clk);
        bus.imem_addr = 32'h10;
        chk("b2b.v0", 64'(bus.imem_valid), 64'd1);
        chk("b2b.d0", bus.imem_data, D_A);
        @(negedge clk);
        bus.imem_req = 1'b0;
        chk("b2b.v1", 64'(bus.imem_valid), 64'd1);
        chk("b2b.d1", bus.imem_data, D_B);
        @(negedge clk);
        chk("b2b.v2", 64'(bus.imem_valid), 64'd1);
        chk("b2b.d2", bus.imem_data, D_C);
        @(negedge clk);
        chk("b2b.end", 64'(bus.imem_valid), 64'd0);

        // faults and boundaries
        fetch("f6", 32'h6, 64'h0, 1'b1);
        fetch("f2000", 32'h2000, 64'h0, 1'b1);
        fetch("f1ffc", 32'h1FFC, 64'h0, 1'b0);
        fetch("fneg", 32'hFFFF_FFF8, 64'h0, 1'b1);

        // out-of-range load must not alias onto word 0
        load(32'h2000, 64'hFFFF_FFFF_FFFF_FFFF);
        fetch("alias", 32'h0, D_A, 1'b0);

        // load_en blocks acceptance; request goes in the cycle after it falls
        bus.load_en   = 1'b1;
        bus.load_addr = 32'h18;
        bus.load_data = D_C2;
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h18;
        #1 chk("ld.ready0", 64'(bus.imem_ready), 64'd0);
        @(negedge clk);
        #1 chk("ld.ready1", 64'(bus.imem_ready), 64'd0);
        @(negedge clk);
        bus.load_en = 1'b0;
        chk("ld.nov2", 64'(bus.imem_valid), 64'd0);
        #1 chk("ld.ready2", 64'(bus.imem_ready), 64'd1);
        @(negedge clk);
        bus.imem_req = 1'b0;
        chk("ld.nov3", 64'(bus.imem_valid), 64'd0);
        @(negedge clk);
        chk("ld.valid", 64'(bus.imem_valid), 64'd1);
        chk("ld.data", bus.imem_data, D_C2);
        @(negedge clk);
        chk("ld.end", 64'(bus.imem_valid), 64'd0);

        // reset with requests in flight
        bus.imem_req  = 1'b1;
        bus.imem_addr = 32'h10;
        @(negedge clk);
        bus.imem_addr = 32'h0;
        @(negedge clk);
        bus.imem_req = 1'b0;
        resetn       = 1'b0;
        @(negedge clk);
        chk("mrst.valid", 64'(bus.imem_valid), 64'd0);
        chk("mrst.data", bus.imem_data, 64'd0);
        chk("mrst.ready", 64'(bus.imem_ready), 64'd0);
        resetn = 1'b1;
        wait_run(n, vseen);
        chk("mrst.cycles", 64'(n), 64'd1024);
        chk("mrst.novalid", 64'(vseen), 64'd0);
        fetch("z10", 32'h10, 64'h0, 1'b0);
        fetch("z00", 32'h0, 64'h0, 1'b0);
        fetch("z18", 32'h18, 64'h0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
